// File: rtl/parity_check_rx.sv
// ---------------------------------------------------------------------------
// parity_check_rx
// Serial frame receiver with parity and stop-bit checking.
// Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1).
// rx_in is looked at only on cycles where bit_en is high; all other cycles
// hold state, so the strobe rate sets the baud rate.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   bit_en      bit-time strobe
//   rx_in       serial line, idle high
//   odd_even    parity mode (0 = even, 1 = odd), latched at the start bit
//   clr_cnt     synchronous clear of err_count (wins over an increment)
//   data_out    last received payload
//   data_valid  one-cycle pulse, one clk after the stop-bit strobe
//   parity_err  parity status of the frame flagged by data_valid
//   frame_err   stop-bit status of the frame flagged by data_valid
//   err_count   saturating count of frames with any error
//   busy        high whenever the FSM is not IDLE
//
// state  | meaning
// IDLE   | waiting for a start bit (rx_in = 0 on a strobe)
// DATA   | shifting in data bits, bit counter = next bit position
// PARITY | waiting for the parity bit strobe
// STOP   | waiting for the stop bit strobe, then report the frame
// ---------------------------------------------------------------------------
module parity_check_rx #(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 rx_in,
  input  logic                 odd_even,
  input  logic                 clr_cnt,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   mode_q, mode_d;
  logic                   par_bit_q, par_bit_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   frame_done;

  // Next-state and frame bookkeeping
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    par_bit_d  = par_bit_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (bit_en && !rx_in) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
          mode_d    = odd_even;
        end
      end
      DATA: begin
        if (bit_en) begin
          shift_d[bit_cnt_q] = rx_in;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_en) begin
          par_bit_d = rx_in;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_en) begin
          state_d    = IDLE;
          frame_done = 1'b1;
          valid_d    = 1'b1;
          data_out_d = shift_q;
          // Expected parity bit is XOR of data, inverted in odd mode.
          perr_d     = par_bit_q ^ (^shift_q) ^ mode_q;
          ferr_d     = ~rx_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error counter: one step per bad frame, saturating; clear wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (frame_done && (perr_d || ferr_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      mode_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      par_bit_q  <= par_bit_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign err_count  = err_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_check_rx.sv
module tb_parity_check_rx;

  localparam int DW   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, bit_en, rx_in, odd_even, clr_cnt;
  logic [DW-1:0] data_out;
  logic          data_valid, parity_err, frame_err, busy;
  logic [CW-1:0] err_count;

  parity_check_rx #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
    .odd_even   (odd_even),
    .clr_cnt    (clr_cnt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int perr;
    int ferr;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 expected=0 at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", int'(data_out), mon_e.data);
        check("parity_err", int'(parity_err), mon_e.perr);
        check("frame_err", int'(frame_err), mon_e.ferr);
        check("err_count", int'(err_count), mon_e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One strobed bit followed by gap non-strobe cycles carrying noise.
  task automatic send_bit(input logic b, input int gap, input logic exp_busy,
                          input logic is_stop);
    bit_en = 1'b1;
    rx_in  = b;
    step();
    bit_en  = 1'b0;
    clr_cnt = 1'b0;
    check("busy_strobe", int'(busy), int'(exp_busy));
    if (is_stop) check("valid_latency", int'(data_valid), 1);
    repeat (gap) begin
      rx_in = 1'($urandom_range(0, 1));
      step();
      check("busy_gap", int'(busy), int'(exp_busy));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic mode,
                            input logic flip, input logic stop, input int gap,
                            input logic clr);
    exp_t e;
    logic par;
    int   bad;
    par = (^data) ^ mode ^ flip;
    odd_even = mode;
    send_bit(1'b0, gap, 1'b1, 1'b0);
    odd_even = 1'($urandom_range(0, 1));
    for (int i = 0; i < DW; i++) send_bit(data[i], gap, 1'b1, 1'b0);
    send_bit(par, gap, 1'b1, 1'b0);
    bad = (flip || !stop) ? 1 : 0;
    if (clr) exp_cnt = 0;
    else if (bad != 0 && exp_cnt < CMAX) exp_cnt++;
    e.data = int'(data);
    e.perr = int'(flip);
    e.ferr = stop ? 0 : 1;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    clr_cnt = clr;
    send_bit(stop, gap, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_data_valid"}, int'(data_valid), 0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    bit_en   = 1'b1;
    rx_in    = 1'b0;
    odd_even = 1'b0;
    clr_cnt  = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst_n   = 1'b1;
    bit_en  = 1'b0;
    clr_cnt = 1'b0;
    rx_in   = 1'b1;
    step();

    // Even mode, good frame for 0xD
    send_frame(4'hD, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    // Odd mode, 0xF with wrong then right parity
    send_frame(4'hF, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'hF, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    // Stop-bit error, then both errors in one frame
    send_frame(4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_frame(4'h5, 1'b0, 1'b1, 1'b0, 1, 1'b0);

    // Saturation: clear, four bad frames, then clear in the valid cycle
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_cnt = 0;
    check("clr_cnt", int'(err_count), 0);
    for (int k = 0; k < 4; k++) send_frame(4'(k + 3), 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'h9, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_cnt = 0;
    check("clr_in_valid_cycle", int'(err_count), 0);
    // Clear coincident with the increment of a bad frame
    send_frame(4'h2, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'hE, 1'b1, 1'b1, 1'b0, 0, 1'b1);

    // Slow strobe, busy tracked across the whole frame
    repeat (2) step();
    check("busy_idle", int'(busy), 0);
    send_frame(4'hA, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    send_frame(4'h7, 1'b0, 1'b1, 1'b1, 3, 1'b0);

    // Reset after two data bits abandons the frame
    odd_even = 1'b0;
    send_bit(1'b0, 0, 1'b1, 1'b0);
    send_bit(1'b0, 0, 1'b1, 1'b0);
    send_bit(1'b1, 0, 1'b1, 1'b0);
    rst_n   = 1'b0;
    bit_en  = 1'b1;
    rx_in   = 1'b0;
    clr_cnt = 1'b0;
    step();
    rst_n  = 1'b1;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    exp_cnt = 0;
    check_all_zero("midreset");
    repeat (3) step();
    check_all_zero("postreset");
    send_frame(4'h6, 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Randomized frames with idle strobes in between
    for (int n = 0; n < 60; n++) begin
      int idle;
      idle = $urandom_range(0, 2);
      repeat (idle) begin
        bit_en = 1'b1;
        rx_in  = 1'b1;
        step();
        bit_en = 1'b0;
        check("busy_idle_strobe", int'(busy), 0);
      end
      send_frame(4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 2),
                 ($urandom_range(0, 9) == 0));
    end

    repeat (5) step();
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
